// File: rtl/data_ctrl_if.sv
// Control/status bundle between data_ctrl and its requester plus the data_path it drives.
// The slave side is data_ctrl; the master side issues start/abort and returns the data_path flags.
interface data_ctrl_if;
    logic       start;
    logic       abort;
    logic       b;
    logic       y_inc;
    logic [1:0] y_select_next;
    logic [1:0] s_step;
    logic       y_en;
    logic       s_en;
    logic       y_store_x;
    logic       s_add;
    logic       s_zero;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, b, y_inc,
        input  y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero, busy, done
    );

    modport slave (
        input  start, abort, b, y_inc,
        output y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero, busy, done
    );
endinterface

// File: rtl/data_ctrl.sv
// Sequencer for data_path: loads y from x, then walks s over N_STEPS bit positions of the live y,
// subtracting s on a set bit and adding one on a clear bit at s==1, and pulses done at the end.
module data_ctrl #(
    parameter int N_STEPS = 8
) (
    input  logic        clk,
    input  logic        rst,
    data_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    typedef struct packed {
        logic       y_en;
        logic       s_en;
        logic       y_store_x;
        logic       s_add;
        logic       s_zero;
        logic       busy;
        logic       done;
        logic       scan;
        logic [1:0] s_step;
    } ctl_t;

    localparam logic [2:0] LAST_CNT = 3'(N_STEPS - 1);

    state_t     state;
    logic [2:0] cnt;
    ctl_t       ctl_q;
    logic       aborting;
    logic       active;
    logic [1:0] sel;

    // Control word presented while sitting in a given state; registered alongside the state.
    function automatic ctl_t ctl_for(input state_t st);
        ctl_t c;
        c = '0;
        case (st)
            LOAD: begin
                c.y_store_x = 1'b1;
                c.y_en      = 1'b1;
                c.s_en      = 1'b1;
                c.s_zero    = 1'b1;
                c.s_add     = 1'b1;
                c.busy      = 1'b1;
            end
            SCAN: begin
                c.y_en   = 1'b1;
                c.s_en   = 1'b1;
                c.s_add  = 1'b1;
                c.s_step = 2'd1;
                c.busy   = 1'b1;
                c.scan   = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            ctl_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                        ctl_q <= ctl_for(LOAD);
                    end else begin
                        ctl_q <= ctl_for(IDLE);
                    end
                end
                LOAD: begin
                    cnt <= 3'd0;
                    if (bus.abort) begin
                        state <= IDLE;
                        ctl_q <= ctl_for(IDLE);
                    end else begin
                        state <= SCAN;
                        ctl_q <= ctl_for(SCAN);
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        ctl_q <= ctl_for(IDLE);
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            ctl_q <= ctl_for(DONE);
                        end else begin
                            ctl_q <= ctl_for(SCAN);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ctl_q <= ctl_for(IDLE);
                end
                default: begin
                    state <= IDLE;
                    ctl_q <= ctl_for(IDLE);
                end
            endcase
        end
    end

    // An abort kills the enables in the same cycle so data_path keeps its partial y and s.
    assign aborting = bus.abort && ((state == LOAD) || (state == SCAN));
    assign active   = rst && !aborting;

    // Mealy select: follows the live b / y_inc from data_path during SCAN.
    always_comb begin
        sel = 2'd0;
        if (ctl_q.scan) begin
            if (bus.b)
                sel = 2'd3;
            else if (bus.y_inc)
                sel = 2'd1;
        end
    end

    assign bus.y_select_next = active ? sel : 2'd0;
    assign bus.s_step        = active ? ctl_q.s_step : 2'd0;
    assign bus.y_en          = active && ctl_q.y_en;
    assign bus.s_en          = active && ctl_q.s_en;
    assign bus.y_store_x     = active && ctl_q.y_store_x;
    assign bus.s_add         = active && ctl_q.s_add;
    assign bus.s_zero        = active && ctl_q.s_zero;
    assign bus.busy          = rst && ctl_q.busy;
    assign bus.done          = rst && ctl_q.done;

endmodule
